// File: rtl/microstep_pkg.sv
// Shared definitions for the microstepper: phase width, resolution codes and
// the microstep increment helper used by the tracker and the config block.
package microstep_pkg;

  localparam int POS_W          = 8;
  localparam int MAX_USTEP_CODE = 6;

  typedef logic [2:0]       ustep_code_t;
  typedef logic [POS_W-1:0] pos_t;

  // Direction as seen after synchronization.
  typedef enum logic {
    DIR_DEC = 1'b0,
    DIR_INC = 1'b1
  } dir_t;

  // Phase increment for one microstep: 64 >> code, codes above 6 clamp to 6.
  function automatic pos_t ustep_inc(input ustep_code_t code);
    ustep_code_t c;
    c = (code > ustep_code_t'(MAX_USTEP_CODE)) ? ustep_code_t'(MAX_USTEP_CODE) : code;
    return pos_t'(8'd64 >> c);
  endfunction

endpackage

// File: rtl/step_edge_sync.sv
// Two-flop synchronizers for STEP and DIR plus a rising-edge detector on the
// synchronized STEP. step_evt is a registered one-cycle pulse and dir_s is
// registered alongside it so both arrive together.
module step_edge_sync (
  input  logic clk,
  input  logic resetn,
  input  logic step,
  input  logic dir,
  output logic step_evt,
  output logic dir_s
);

  logic [1:0] step_sync;
  logic [1:0] dir_sync;
  logic       step_prev;

  // Synchronize, remember the previous level and register the rising edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the chain a chain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      step_sync <= '0;
      dir_sync  <= '0;
      step_prev <= 1'b0;
      step_evt  <= 1'b0;
      dir_s     <= 1'b0;
    end else begin
      step_sync <= {step_sync[0], step};
      dir_sync  <= {dir_sync[0], dir};
      step_prev <= step_sync[1];
      step_evt  <= step_sync[1] & ~step_prev;
      dir_s     <= dir_sync[1];
    end
  end

endmodule

// File: rtl/microstep_phase_tracker.sv
// Step/direction front end: turns synchronized STEP edges into the 8-bit
// electrical phase, keeps a signed step count and drops steps that arrive
// faster than MIN_GAP cycles apart, flagging them in a sticky overrun bit.
module microstep_phase_tracker
  import microstep_pkg::*;
#(
  parameter int               MIN_GAP   = 4,
  parameter int               CNT_W     = 32,
  parameter logic [POS_W-1:0] RESET_POS = 8'd0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    step,
  input  logic                    dir,
  input  logic                    enable,
  input  logic [2:0]              usteps,
  input  logic                    clear_fault,
  output logic [POS_W-1:0]        pos,
  output logic                    pos_valid,
  output logic signed [CNT_W-1:0] step_count,
  output logic                    step_overrun
);

  localparam int GAP_W = (MIN_GAP < 2) ? 1 : $clog2(MIN_GAP + 1);

  logic             step_evt;
  logic             dir_s;
  logic [GAP_W-1:0] gap;
  logic             gap_ok;
  logic             accept;
  logic             reject;
  pos_t             inc;
  pos_t             low_mask;
  pos_t             base;
  pos_t             pos_next;

  step_edge_sync u_sync (
    .clk      (clk),
    .resetn   (resetn),
    .step     (step),
    .dir      (dir),
    .step_evt (step_evt),
    .dir_s    (dir_s)
  );

  // With MIN_GAP = 0 the counter stays at 0 and every edge passes.
  assign gap_ok = (gap >= GAP_W'(MIN_GAP));
  assign accept = step_evt & enable & gap_ok;
  assign reject = step_evt & enable & ~gap_ok;

  // Next phase: snap to the current resolution grid, then move one microstep.
  // Moving down from an off-grid position only floors to the grid.
  // NOTE: every always_comb output gets a default first so no path can hold a
  // stale value, which is what would otherwise infer a latch.
  always_comb begin
    inc      = ustep_inc(ustep_code_t'(usteps));
    low_mask = inc - pos_t'(1);
    base     = pos & ~low_mask;
    pos_next = base;
    if (dir_t'(dir_s) == DIR_INC) begin
      pos_next = base + inc;
    end else if ((pos & low_mask) == '0) begin
      pos_next = base - inc;
    end
  end

  // Rate guard: cycles since the last accepted step, saturating at MIN_GAP.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gap <= GAP_W'(MIN_GAP);
    end else if (accept) begin
      gap <= '0;
    end else if (gap < GAP_W'(MIN_GAP)) begin
      gap <= gap + GAP_W'(1);
    end
  end

  // Phase, strobe and signed count move together on an accepted step.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pos        <= RESET_POS;
      pos_valid  <= 1'b0;
      step_count <= '0;
    end else begin
      pos_valid <= accept;
      if (accept) begin
        pos <= pos_next;
        if (dir_t'(dir_s) == DIR_INC) begin
          step_count <= step_count + CNT_W'(1);
        end else begin
          step_count <= step_count - CNT_W'(1);
        end
      end
    end
  end

  // Sticky overrun flag; a dropped step in the same cycle beats the clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      step_overrun <= 1'b0;
    end else if (reject) begin
      step_overrun <= 1'b1;
    end else if (clear_fault) begin
      step_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_microstep_phase_tracker.sv
// Scoreboard bench for microstep_phase_tracker: each issued step pushes its
// hand-computed phase, count and strobe cycle; a monitor pops on pos_valid.
module tb_microstep_phase_tracker;

  logic               clk;
  logic               resetn;
  logic               step;
  logic               dir;
  logic               enable;
  logic [2:0]         usteps;
  logic               clear_fault;
  logic [7:0]         pos;
  logic               pos_valid;
  logic signed [31:0] step_count;
  logic               step_overrun;

  typedef struct {
    logic [7:0] pos;
    longint     cnt;
    longint     cyc;
  } exp_t;

  exp_t   exp_q[$];
  longint cyc;
  int     passed;
  int     total;

  microstep_phase_tracker #(
    .MIN_GAP   (4),
    .CNT_W     (32),
    .RESET_POS (8'd0)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .step         (step),
    .dir          (dir),
    .enable       (enable),
    .usteps       (usteps),
    .clear_fault  (clear_fault),
    .pos          (pos),
    .pos_valid    (pos_valid),
    .step_count   (step_count),
    .step_overrun (step_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to check strobe latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every strobe must match the oldest expected step.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pos_valid) begin
        check("strobe_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("pos", longint'(pos), longint'(e.pos));
          check("step_count", longint'(step_count), e.cnt);
          check("strobe_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    step   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pos", longint'(pos), 0);
    check("rst_pos_valid", longint'(pos_valid), 0);
    check("rst_step_count", longint'(step_count), 0);
    check("rst_overrun", longint'(step_overrun), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // One well-formed step: rising edge, 5 clk high, 5 clk low.
  task automatic do_step(input bit expect_it, input logic [7:0] p, input longint c);
    exp_t e;
    repeat (2) @(negedge clk);
    step = 1'b1;
    if (expect_it) begin
      e.pos = p;
      e.cnt = c;
      e.cyc = cyc + 4;
      exp_q.push_back(e);
    end
    repeat (5) @(negedge clk);
    step = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    cyc         = 0;
    passed      = 0;
    total       = 0;
    resetn      = 1'b0;
    step        = 1'b0;
    dir         = 1'b1;
    enable      = 1'b1;
    usteps      = 3'd6;
    clear_fault = 1'b0;

    // Fine resolution, five steps up.
    do_reset();
    usteps = 3'd6; dir = 1'b1;
    for (int i = 1; i <= 5; i++) do_step(1'b1, 8'(i), longint'(i));
    check("count_after_5", longint'(step_count), 5);

    // Full steps up with wrap, then one down across zero.
    do_reset();
    usteps = 3'd0; dir = 1'b1;
    do_step(1'b1, 8'd64, 1);
    do_step(1'b1, 8'd128, 2);
    do_step(1'b1, 8'd192, 3);
    do_step(1'b1, 8'd0, 4);
    dir = 1'b0;
    do_step(1'b1, 8'd192, 3);

    // Reach 37, then check grid alignment up (ceil) and down (floor only).
    do_reset();
    usteps = 3'd3; dir = 1'b1;
    for (int i = 1; i <= 4; i++) do_step(1'b1, 8'(8 * i), longint'(i));
    usteps = 3'd7;  // clamps to 6
    for (int i = 5; i <= 9; i++) do_step(1'b1, 8'(28 + i), longint'(i));
    usteps = 3'd4;
    do_step(1'b1, 8'd40, 10);
    usteps = 3'd6; dir = 1'b0;
    do_step(1'b1, 8'd39, 9);
    do_step(1'b1, 8'd38, 8);
    do_step(1'b1, 8'd37, 7);
    usteps = 3'd4;
    do_step(1'b1, 8'd36, 6);

    // Rate guard: two edges 2 clk apart, second one dropped.
    do_reset();
    usteps = 3'd6; dir = 1'b1;
    repeat (8) @(negedge clk);
    step = 1'b1;
    e.pos = 8'd1; e.cnt = 1; e.cyc = cyc + 4;
    exp_q.push_back(e);
    @(negedge clk); step = 1'b0;
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    repeat (8) @(negedge clk);
    check("overrun_set", longint'(step_overrun), 1);
    check("pos_after_drop", longint'(pos), 1);
    check("count_after_drop", longint'(step_count), 1);
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    check("overrun_cleared", longint'(step_overrun), 0);
    do_step(1'b1, 8'd2, 2);

    // Disabled: steps ignored silently.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) do_step(1'b0, 8'd0, 0);
    check("dis_pos", longint'(pos), 2);
    check("dis_count", longint'(step_count), 2);
    check("dis_overrun", longint'(step_overrun), 0);
    enable = 1'b1;

    // Reset one cycle after a step edge: nothing may come out afterwards.
    repeat (2) @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_pos", longint'(pos), 0);
    check("midrst_count", longint'(step_count), 0);
    check("midrst_pos_valid", longint'(pos_valid), 0);
    step = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_pos", longint'(pos), 0);
    check("post_rst_count", longint'(step_count), 0);
    check("pending_expected", longint'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
